hazard_ctrl_v2: RTL and testbench

//   Parametrised pipeline hazard controller for the 5-stage RV32I core; successor to the combinational stall/flush unit.

---
 rtl/hazard_ctrl_v2.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl_v2.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_v2.sv
// hazard_ctrl_v2 - pipeline hazard controller for the 5-stage RV32I core.
//
// Produces stall/bubble/flush controls for the IF/ID/EX/MEM pipeline registers:
//   - load-use detection that inserts LU_CYCLES bubbles per hazard
//   - memory-wait FSM (IDLE/WAIT/ERR) with an uncached MMIO window and timeout
//   - priority: cache_stall > flush > load-use
//   - saturating performance counters for stall and flush cycles
//
// Ports:
//   clk, rstn                 core clock, asynchronous active-low reset
//   ex_opcode/ex_branch/ex_rd EX-stage instruction info (branch taken resolved in EX)
//   id_rs1/id_rs2/_used       ID-stage source registers and their use flags
//   mem_addr                  MEM-stage access address
//   w_valid/w_ready           cache write request / done
//   r_valid/r_ready           cache read request / done
//   perf_clr                  synchronous clear of both counters
//   stall_front               hold PC and IF/ID
//   bubble_ex                 load NOP into ID/EX
//   cache_stall               freeze every pipeline register
//   flush                     squash IF/ID and ID/EX
//   timeout_err               sticky memory-wait timeout flag
//   cnt_stall, cnt_flush      saturating cycle counters
module hazard_ctrl_v2 #(
   parameter int                XLEN      = 32,
   parameter int                LU_CYCLES = 1,
   parameter logic [XLEN-1:0]   MMIO_MASK = 32'hFFFFFF00,
   parameter logic [XLEN-1:0]   MMIO_BASE = 32'h0,
   parameter int                TIMEOUT   = 1024,
   parameter int                CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [6:0]       ex_opcode,
   input  logic             ex_branch,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [XLEN-1:0]  mem_addr,
   input  logic             w_valid,
   input  logic             w_ready,
   input  logic             r_valid,
   input  logic             r_ready,
   input  logic             perf_clr,
   output logic             stall_front,
   output logic             bubble_ex,
   output logic             cache_stall,
   output logic             flush,
   output logic             timeout_err,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_flush
);

   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LOAD = 7'b0000011;

   // Wait counter only needs to reach TIMEOUT; with the timeout disabled it
   // may wrap harmlessly since it is never compared.
   localparam int             WCW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WCW-1:0] TO_VAL = WCW'(TIMEOUT);
   localparam logic [1:0]     LU_LD  = 2'(LU_CYCLES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR} mem_st_e;

   mem_st_e          st_q, st_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [1:0]       lu_cnt_q, lu_cnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
   logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

   logic req, cacheable, cs, fl, sf, lu_hit, cf_cond;

   always_comb begin
      req       = (w_valid & ~w_ready) | (r_valid & ~r_ready);
      cacheable = (mem_addr & MMIO_MASK) != MMIO_BASE;

      st_d       = st_q;
      wait_cnt_d = wait_cnt_q;
      cs         = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (req && cacheable) begin
               cs         = 1'b1;
               st_d       = ST_WAIT;
               wait_cnt_d = WCW'(1);
            end
         end
         ST_WAIT: begin
            cs = req;
            if (!req)
               st_d = ST_IDLE;
            else if ((TIMEOUT != 0) && (wait_cnt_q == TO_VAL))
               st_d = ST_ERR;
            else
               wait_cnt_d = wait_cnt_q + WCW'(1);
         end
         ST_ERR:  st_d = ST_ERR;
         default: st_d = ST_IDLE;
      endcase
      // Outputs are forced low while reset is held so no stall leaks out
      // of the combinational paths before the first clock.
      cs = cs & rstn;
      timeout_err_d = (st_d == ST_ERR);

      cf_cond = ex_branch | (ex_opcode == OP_JAL) | (ex_opcode == OP_JALR);
      fl      = cf_cond & ~cs & rstn;

      lu_hit = (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));
      sf     = ((lu_cnt_q != 2'd0) || lu_hit) && !cs && !fl && rstn;

      // Bubble counter: frozen by cache stalls, killed by a flush.
      lu_cnt_d = lu_cnt_q;
      if (cs)                    lu_cnt_d = lu_cnt_q;
      else if (fl)               lu_cnt_d = 2'd0;
      else if (lu_cnt_q != 2'd0) lu_cnt_d = lu_cnt_q - 2'd1;
      else if (lu_hit)           lu_cnt_d = LU_LD;

      cnt_stall_d = cnt_stall_q;
      cnt_flush_d = cnt_flush_q;
      if (perf_clr) begin
         cnt_stall_d = '0;
         cnt_flush_d = '0;
      end else begin
         if ((sf || cs) && (cnt_stall_q != {CNT_W{1'b1}})) cnt_stall_d = cnt_stall_q + 1'b1;
         if (fl && (cnt_flush_q != {CNT_W{1'b1}}))         cnt_flush_d = cnt_flush_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q          <= ST_IDLE;
         wait_cnt_q    <= '0;
         lu_cnt_q      <= 2'd0;
         timeout_err_q <= 1'b0;
         cnt_stall_q   <= '0;
         cnt_flush_q   <= '0;
      end else begin
         st_q          <= st_d;
         wait_cnt_q    <= wait_cnt_d;
         lu_cnt_q      <= lu_cnt_d;
         timeout_err_q <= timeout_err_d;
         cnt_stall_q   <= cnt_stall_d;
         cnt_flush_q   <= cnt_flush_d;
      end
   end

   assign cache_stall = cs;
   assign flush       = fl;
   assign stall_front = sf;
   assign bubble_ex   = sf;
   assign timeout_err = timeout_err_q;
   assign cnt_stall   = cnt_stall_q;
   assign cnt_flush   = cnt_flush_q;

endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// tb_hazard_ctrl_v2 - directed scenarios followed by random traffic; a driver
// applies one stimulus per cycle and pushes the reference model's expected
// outputs into a queue, a monitor pops and compares on the falling edge.
module tb_hazard_ctrl_v2;

   localparam int LU_CYC = 2;
   localparam int TO     = 4;
   localparam int CW     = 4;
   localparam int CMAX   = (1 << CW) - 1;

   localparam logic [6:0] LOAD = 7'b0000011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] ALU  = 7'b0110011;

   typedef struct {
      logic        rstn;
      logic [6:0]  op;
      logic        br;
      logic [4:0]  rd, rs1, rs2;
      logic        u1, u2;
      logic [31:0] addr;
      logic        wv, wr, rv, rr, clr;
   } stim_t;

   typedef struct {
      logic cs, sf, fl, te;
      int   cst, cfl;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [6:0]    ex_opcode = '0;
   logic          ex_branch = 1'b0;
   logic [4:0]    ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
   logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
   logic [31:0]   mem_addr = '0;
   logic          w_valid = 1'b0, w_ready = 1'b0, r_valid = 1'b0, r_ready = 1'b0;
   logic          perf_clr = 1'b0;
   logic          stall_front, bubble_ex, cache_stall, flush, timeout_err;
   logic [CW-1:0] cnt_stall, cnt_flush;

   hazard_ctrl_v2 #(.XLEN(32), .LU_CYCLES(LU_CYC), .MMIO_MASK(32'hFFFFFF00),
                    .MMIO_BASE(32'h0), .TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rstn(rstn), .ex_opcode(ex_opcode), .ex_branch(ex_branch),
      .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .mem_addr(mem_addr), .w_valid(w_valid),
      .w_ready(w_ready), .r_valid(r_valid), .r_ready(r_ready), .perf_clr(perf_clr),
      .stall_front(stall_front), .bubble_ex(bubble_ex), .cache_stall(cache_stall),
      .flush(flush), .timeout_err(timeout_err), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush));

   always #5 clk = ~clk;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   bit   done = 0;

   // Reference model state, in plain terms: how long the current memory wait
   // has lasted (0 = no wait in progress), whether we have timed out, how many
   // extra bubbles remain, and the two cycle tallies.
   int m_wait = 0;
   bit m_err = 0;
   int m_bub = 0;
   int m_cst = 0;
   int m_cfl = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input stim_t s, output exp_t e);
      bit req, cacheable, cf, hit;
      e = '{cs:0, sf:0, fl:0, te:0, cst:0, cfl:0};
      if (!s.rstn) begin
         m_wait = 0; m_err = 0; m_bub = 0; m_cst = 0; m_cfl = 0;
         return;
      end
      req       = (s.wv && !s.wr) || (s.rv && !s.rr);
      cacheable = (s.addr & 32'hFFFFFF00) != 32'h0;
      if (m_err)            e.cs = 0;
      else if (m_wait == 0) e.cs = req && cacheable;
      else                  e.cs = req;
      cf   = s.br || s.op == JAL || s.op == JALR;
      e.fl = cf && !e.cs;
      hit  = s.op == LOAD && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
      e.sf = (m_bub > 0 || hit) && !e.cs && !e.fl;
      e.te  = m_err;
      e.cst = m_cst;
      e.cfl = m_cfl;
      // advance
      if (!m_err) begin
         if (m_wait == 0) begin
            if (e.cs) m_wait = 1;
         end else if (!req) m_wait = 0;
         else if (m_wait == TO) begin m_err = 1; m_wait = 0; end
         else m_wait++;
      end
      if (!e.cs) begin
         if (e.fl)           m_bub = 0;
         else if (m_bub > 0) m_bub--;
         else if (hit)       m_bub = LU_CYC - 1;
      end
      if (s.clr) begin
         m_cst = 0; m_cfl = 0;
      end else begin
         if ((e.sf || e.cs) && m_cst < CMAX) m_cst++;
         if (e.fl && m_cfl < CMAX)           m_cfl++;
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{rstn:1, op:ALU, br:0, rd:0, rs1:0, rs2:0, u1:0, u2:0,
            addr:32'h0, wv:0, wr:0, rv:0, rr:0, clr:0};
      return s;
   endfunction

   task automatic cyc(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rstn = s.rstn; ex_opcode = s.op; ex_branch = s.br; ex_rd = s.rd;
      id_rs1 = s.rs1; id_rs2 = s.rs2; id_rs1_used = s.u1; id_rs2_used = s.u2;
      mem_addr = s.addr; w_valid = s.wv; w_ready = s.wr; r_valid = s.rv;
      r_ready = s.rr; perf_clr = s.clr;
      model_step(s, e);
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      stim_t s;
      s = idle();
      s.rstn = 0;
      cyc(s);
      cyc(s);
   endtask

   // Monitor: outputs are settled mid-cycle, one expectation per cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("cache_stall", int'(cache_stall), int'(e.cs));
         check("stall_front", int'(stall_front), int'(e.sf));
         check("bubble_ex",   int'(bubble_ex),   int'(e.sf));
         check("flush",       int'(flush),       int'(e.fl));
         check("timeout_err", int'(timeout_err), int'(e.te));
         check("cnt_stall",   int'(cnt_stall),   e.cst);
         check("cnt_flush",   int'(cnt_flush),   e.cfl);
      end
   end

   initial begin
      stim_t s;
      do_reset();

      // load-use on rs1: two bubbles
      s = idle(); s.op = LOAD; s.rd = 5; s.rs1 = 5; s.u1 = 1; cyc(s);
      repeat (3) cyc(idle());
      // rd=0 and unused rs2 never stall
      s = idle(); s.op = LOAD; s.rd = 0; s.rs1 = 0; s.u1 = 1; cyc(s);
      s = idle(); s.op = LOAD; s.rd = 5; s.rs2 = 5; s.u2 = 0; cyc(s);
      cyc(idle());

      // cacheable read, ready low 3 cycles then done
      s = idle(); s.rv = 1; s.addr = 32'h1000;
      repeat (3) cyc(s);
      s.rr = 1; cyc(s);
      cyc(idle());
      // same in the MMIO window
      s = idle(); s.rv = 1; s.addr = 32'h40;
      repeat (3) cyc(s);
      s.rr = 1; cyc(s);

      // branch under cache stall, then released
      s = idle(); s.rv = 1; s.addr = 32'h2000; s.br = 1;
      repeat (2) cyc(s);
      s.rr = 1; cyc(s);
      cyc(idle());

      // branch together with a load-use hit
      do_reset();
      s = idle(); s.op = LOAD; s.rd = 7; s.rs2 = 7; s.u2 = 1; s.br = 1; cyc(s);
      repeat (2) cyc(idle());

      // perf_clr while counters would increment
      s = idle(); s.br = 1; s.clr = 1; cyc(s);
      cyc(idle());

      // write timeout then sticky until reset
      s = idle(); s.wv = 1; s.addr = 32'h8000;
      repeat (8) cyc(s);
      repeat (2) cyc(idle());
      do_reset();

      // counter saturation
      s = idle(); s.op = JAL;
      repeat (20) cyc(s);
      s = idle(); s.op = LOAD; s.rd = 3; s.rs1 = 3; s.u1 = 1;
      repeat (20) cyc(s);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         int r;
         s = idle();
         s.rstn = ($urandom_range(0, 199) != 0);
         r = $urandom_range(0, 99);
         s.op  = (r < 40) ? LOAD : (r < 45) ? JAL : (r < 50) ? JALR : ALU;
         s.br  = ($urandom_range(0, 9) == 0);
         s.rd  = 5'($urandom_range(0, 3));
         s.rs1 = 5'($urandom_range(0, 3));
         s.rs2 = 5'($urandom_range(0, 3));
         s.u1  = 1'($urandom_range(0, 1));
         s.u2  = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 2);
         s.addr = (r == 0) ? 32'h40 : (r == 1) ? 32'h1000 : $urandom;
         s.rv  = ($urandom_range(0, 4) == 0);
         s.rr  = ($urandom_range(0, 9) < 4);
         s.wv  = ($urandom_range(0, 9) == 0);
         s.wr  = ($urandom_range(0, 9) < 4);
         s.clr = ($urandom_range(0, 29) == 0);
         cyc(s);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
